// File: rtl/stream_prefetcher.sv
// rtl/stream_prefetcher.sv - next-line stream prefetcher with line-fill FIFO toward the cache
// Optional feature: define PF_DEDUP_EN to skip candidates already buffered in the FIFO.
module stream_prefetcher #(
    parameter int LINE_BYTES = 32,
    parameter int DEGREE     = 2,
    parameter int BUF_DEPTH  = 4,
    parameter int WAY_W      = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    trig_valid,
    input  logic [31:0]             trig_addr,
    input  logic [WAY_W-1:0]        trig_way,
    output logic                    busy,
    output logic                    pf_read,
    output logic [31:0]             pf_address,
    input  logic [8*LINE_BYTES-1:0] pf_rdata,
    input  logic                    pf_resp,
    output logic                    fill_valid,
    output logic [31:0]             fill_addr,
    output logic [8*LINE_BYTES-1:0] fill_data,
    output logic [WAY_W-1:0]        fill_way,
    input  logic                    fill_ack
);

    localparam int DW = 8 * LINE_BYTES;
    localparam int KW = $clog2(DEGREE + 1);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0]   LINE_MASK = ~(32'(LINE_BYTES) - 32'd1);
    localparam logic [KW-1:0] K_LAST    = KW'(DEGREE);
    localparam logic [CW-1:0] FULL_CNT  = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        STALL = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       base_q, base_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic [KW-1:0]     k_q, k_d;
    logic              pf_read_q, pf_read_d;
    logic [31:0]       pf_address_q, pf_address_d;

    logic [31:0]       mem_addr_q [BUF_DEPTH];
    logic [31:0]       mem_addr_d [BUF_DEPTH];
    logic [DW-1:0]     mem_data_q [BUF_DEPTH];
    logic [DW-1:0]     mem_data_d [BUF_DEPTH];
    logic [WAY_W-1:0]  mem_way_q  [BUF_DEPTH];
    logic [WAY_W-1:0]  mem_way_d  [BUF_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic              push;
    logic              pop;
    logic              room;
    logic              dup_hit;
    logic [31:0]       cand_addr;

    assign fill_valid = (count_q != '0);
    assign pop        = fill_valid & fill_ack;
    // An entry leaving on this edge already counts as free space.
    assign room       = (count_q != FULL_CNT) | pop;
    assign cand_addr  = base_q + 32'(k_q) * 32'(LINE_BYTES);

`ifdef PF_DEDUP_EN
    logic [BUF_DEPTH-1:0] entry_valid;

    always_comb begin
        dup_hit     = 1'b0;
        entry_valid = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            entry_valid[i] = CW'(PW'(PW'(i) - rd_ptr_q)) < count_q;
            if (entry_valid[i] && (mem_addr_q[i] == cand_addr)) begin
                dup_hit = 1'b1;
            end
        end
    end
`else
    assign dup_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        way_d        = way_q;
        k_d          = k_q;
        pf_read_d    = pf_read_q;
        pf_address_d = pf_address_q;
        push         = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig_valid) begin
                    base_d  = trig_addr & LINE_MASK;
                    way_d   = trig_way;
                    k_d     = KW'(1);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (dup_hit) begin
                    if (k_q == K_LAST) begin
                        state_d = IDLE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end else if (room) begin
                    pf_read_d    = 1'b1;
                    pf_address_d = cand_addr;
                    state_d      = WAIT;
                end else begin
                    state_d = STALL;
                end
            end
            WAIT: begin
                if (pf_resp) begin
                    push      = 1'b1;
                    pf_read_d = 1'b0;
                    if (k_q == K_LAST) begin
                        state_d = IDLE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            STALL: begin
                if (pop) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A push can never hit a full FIFO: ISSUE only launches a read when a slot is free.
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_way_d  = mem_way_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            mem_addr_d[wr_ptr_q] = pf_address_q;
            mem_data_d[wr_ptr_q] = pf_rdata;
            mem_way_d[wr_ptr_q]  = way_q;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            base_q       <= '0;
            way_q        <= '0;
            k_q          <= '0;
            pf_read_q    <= 1'b0;
            pf_address_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_addr_q[i] <= '0;
                mem_data_q[i] <= '0;
                mem_way_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            way_q        <= way_d;
            k_q          <= k_d;
            pf_read_q    <= pf_read_d;
            pf_address_q <= pf_address_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_addr_q[i] <= mem_addr_d[i];
                mem_data_q[i] <= mem_data_d[i];
                mem_way_q[i]  <= mem_way_d[i];
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign pf_read    = pf_read_q;
    assign pf_address = pf_address_q;
    assign fill_addr  = fill_valid ? mem_addr_q[rd_ptr_q] : '0;
    assign fill_data  = fill_valid ? mem_data_q[rd_ptr_q] : '0;
    assign fill_way   = fill_valid ? mem_way_q[rd_ptr_q]  : '0;

endmodule

// File: tb/tb_stream_prefetcher.sv
// tb/tb_stream_prefetcher.sv - randomized bench for stream_prefetcher against a queue-based reference model
module tb_stream_prefetcher;

    localparam int LINE_BYTES = 32;
    localparam int DEGREE     = 3;
    localparam int BUF_DEPTH  = 4;
    localparam int WAY_W      = 2;
    localparam int DW         = 8 * LINE_BYTES;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                trig_valid;
    logic [31:0]         trig_addr;
    logic [WAY_W-1:0]    trig_way;
    logic                busy;
    logic                pf_read;
    logic [31:0]         pf_address;
    logic [DW-1:0]       pf_rdata;
    logic                pf_resp;
    logic                fill_valid;
    logic [31:0]         fill_addr;
    logic [DW-1:0]       fill_data;
    logic [WAY_W-1:0]    fill_way;
    logic                fill_ack;

    always #5 clk = ~clk;

    stream_prefetcher #(
        .LINE_BYTES(LINE_BYTES),
        .DEGREE    (DEGREE),
        .BUF_DEPTH (BUF_DEPTH),
        .WAY_W     (WAY_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst_n),
        .trig_valid(trig_valid),
        .trig_addr (trig_addr),
        .trig_way  (trig_way),
        .busy      (busy),
        .pf_read   (pf_read),
        .pf_address(pf_address),
        .pf_rdata  (pf_rdata),
        .pf_resp   (pf_resp),
        .fill_valid(fill_valid),
        .fill_addr (fill_addr),
        .fill_data (fill_data),
        .fill_way  (fill_way),
        .fill_ack  (fill_ack)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    typedef struct {
        logic [31:0]      addr;
        logic [DW-1:0]    data;
        logic [WAY_W-1:0] way;
    } entry_t;

    // Reference: list of lines still to fetch for the current trigger, plus the fill queue.
    entry_t           m_fifo[$];
    logic [31:0]      m_todo[$];
    bit               m_active;
    bit               m_decide;
    bit               m_stalled;
    bit               m_out;
    logic [31:0]      m_cur;
    logic [WAY_W-1:0] m_way;
    int               resp_wait;

    task automatic model_reset();
        m_fifo.delete();
        m_todo.delete();
        m_active  = 0;
        m_decide  = 0;
        m_stalled = 0;
        m_out     = 0;
        m_cur     = '0;
        m_way     = '0;
        resp_wait = 0;
    endtask

    task automatic compare_outputs();
        check("busy", busy, m_active);
        check("pf_read", pf_read, m_out);
        if (m_out) check("pf_address", pf_address, m_cur);
        check("fill_valid", fill_valid, m_fifo.size() != 0);
        if (m_fifo.size() != 0) begin
            check("fill_addr", fill_addr, m_fifo[0].addr);
            check("fill_data", fill_data, m_fifo[0].data);
            check("fill_way", fill_way, m_fifo[0].way);
        end
    endtask

    task automatic model_edge();
        bit          pop;
        bit          push;
        entry_t      e;
        logic [31:0] base;
        pop  = (m_fifo.size() != 0) && fill_ack;
        push = 0;
        if (!m_active) begin
            if (trig_valid) begin
                base = trig_addr & ~(32'(LINE_BYTES) - 32'd1);
                for (int k = 1; k <= DEGREE; k++) m_todo.push_back(base + 32'(k * LINE_BYTES));
                m_way    = trig_way;
                m_active = 1;
                m_decide = 1;
            end
        end else if (m_decide) begin
            m_decide = 0;
            if (m_fifo.size() < BUF_DEPTH || pop) begin
                m_out     = 1;
                m_cur     = m_todo.pop_front();
                resp_wait = $urandom_range(0, 4);
            end else begin
                m_stalled = 1;
            end
        end else if (m_stalled) begin
            if (pop) begin
                m_stalled = 0;
                m_decide  = 1;
            end
        end else if (m_out && pf_resp) begin
            push   = 1;
            e.addr = m_cur;
            e.data = pf_rdata;
            e.way  = m_way;
            m_out  = 0;
            if (m_todo.size() == 0) m_active = 0;
            else m_decide = 1;
        end
        if (pop) void'(m_fifo.pop_front());
        if (push) m_fifo.push_back(e);
    endtask

    task automatic cycle(input bit tv, input logic [31:0] ta, input logic [WAY_W-1:0] tw,
                         input int ack_pct, input int spur_pct);
        compare_outputs();
        trig_valid = tv;
        trig_addr  = ta;
        trig_way   = tw;
        fill_ack   = ($urandom_range(0, 99) < ack_pct);
        for (int i = 0; i < 8; i++) pf_rdata[i*32 +: 32] = $urandom;
        if (m_out) begin
            pf_resp = (resp_wait == 0);
            if (resp_wait > 0) resp_wait--;
        end else begin
            pf_resp = ($urandom_range(0, 99) < spur_pct);
        end
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n, input int ack_pct);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, '0, ack_pct, 0);
    endtask

    initial begin
        logic [31:0] ra;
        int          ack;
        rst_n      = 1'b0;
        trig_valid = 1'b0;
        trig_addr  = '0;
        trig_way   = '0;
        pf_rdata   = '0;
        pf_resp    = 1'b0;
        fill_ack   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_pf_read", pf_read, 1'b0);
        check("rst_pf_address", pf_address, 32'h0);
        check("rst_fill_valid", fill_valid, 1'b0);
        check("rst_fill_addr", fill_addr, 32'h0);
        check("rst_fill_data", fill_data, '0);
        check("rst_fill_way", fill_way, '0);
        rst_n = 1'b1;

        // Unaligned trigger, then address wrap at the top of the space.
        cycle(1'b1, 32'h0000_1013, 2'd1, 100, 0);
        idle_cycles(25, 100);
        cycle(1'b1, 32'hFFFF_FFE0, 2'd2, 100, 0);
        idle_cycles(25, 100);

        // Back-pressure: two triggers with the cache not accepting fills forces a stall.
        cycle(1'b1, 32'h0000_2000, 2'd3, 0, 0);
        idle_cycles(25, 0);
        cycle(1'b1, 32'h0000_3000, 2'd0, 0, 0);
        idle_cycles(25, 0);
        check("stall_fifo_full", fill_valid && m_fifo.size() == BUF_DEPTH, 1'b1);
        check("stall_no_read", pf_read, 1'b0);
        cycle(1'b0, 32'h0, '0, 100, 0);
        idle_cycles(40, 100);

        // Overlapping line ranges: duplicates are requested and buffered again.
        cycle(1'b1, 32'h0000_1020, 2'd1, 0, 0);
        idle_cycles(25, 0);
        cycle(1'b1, 32'h0000_1000, 2'd2, 0, 0);
        idle_cycles(25, 0);
        idle_cycles(40, 100);

        // Reset while a read is outstanding; a late response must be ignored.
        cycle(1'b1, 32'h0000_5000, 2'd2, 100, 0);
        for (int i = 0; i < 20 && !m_out; i++) cycle(1'b0, 32'h0, '0, 100, 0);
        check("reached_wait", m_out, 1'b1);
        resp_wait = 50;
        pf_resp   = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        #1;
        check("midrst_pf_read", pf_read, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_fill_valid", fill_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 32'h0, '0, 100, 100);
        cycle(1'b0, 32'h0, '0, 100, 100);
        idle_cycles(3, 100);

        // Random traffic: triggers while busy, spurious responses, variable back-pressure.
        for (int i = 0; i < 2400; i++) begin
            case ($urandom_range(0, 2))
                0:       ra = $urandom;
                1:       ra = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
                default: ra = 32'h0000_1000 + 32'($urandom_range(0, 7) * LINE_BYTES);
            endcase
            ack = (((i / 400) % 3) == 0) ? 20 : ((((i / 400) % 3) == 1) ? 60 : 100);
            cycle($urandom_range(0, 3) == 0, ra, WAY_W'($urandom), ack, 10);
        end
        idle_cycles(60, 100);
        check("drain_busy", busy, 1'b0);
        check("drain_fill_valid", fill_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
